// File: rtl/csr_dec_hls_deadlock_report_ctrl.sv
// Deadlock qualifier and round-robin reporter for per-instance HLS monitors.
// Optional: `define CSR_DEC_DEADLOCK_TIMESTAMP_EN adds a cycle stamp on rpt_ts.
module csr_dec_hls_deadlock_report_ctrl #(
  parameter int N_MON  = 4,
  parameter int THRESH = 16,
  localparam int IDX_W = (N_MON > 1) ? $clog2(N_MON) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [N_MON-1:0] mon_block,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [IDX_W-1:0] rpt_idx,
  output logic [31:0]      rpt_ts,
  output logic             deadlock,
  output logic             sticky,
  input  logic             clr_sticky
);

  localparam logic [7:0] TH = 8'(THRESH);

  typedef enum logic {
    IDLE,
    REPORT
  } state_t;

  state_t           state_q;
  logic [7:0]       cnt_q [N_MON];
  logic [N_MON-1:0] qual;
  logic [N_MON-1:0] reported_q;
  logic [N_MON-1:0] pending;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] gnt;
  logic             found;
  logic             hs;
  logic             grant_go;
  int               j;

  assign hs       = rpt_valid & rpt_ready;
  assign pending  = qual & ~reported_q;
  assign grant_go = (state_q == IDLE) && (|pending);

  for (genvar i = 0; i < N_MON; i++) begin : g_mon
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q[i] <= '0;
      end else if (!enable || !mon_block[i]) begin
        cnt_q[i] <= '0;
      end else if (cnt_q[i] != TH) begin
        cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end

    assign qual[i] = (cnt_q[i] == TH);

    // Dropping the block line re-arms the monitor, even mid-handshake.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        reported_q[i] <= 1'b0;
      end else if (!mon_block[i]) begin
        reported_q[i] <= 1'b0;
      end else if (hs && (rpt_idx == IDX_W'(i))) begin
        reported_q[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deadlock <= 1'b0;
      sticky   <= 1'b0;
    end else begin
      deadlock <= |qual;
      if (deadlock) begin
        sticky <= 1'b1;
      end else if (clr_sticky) begin
        sticky <= 1'b0;
      end
    end
  end

  // Scan starts one past the last granted index.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_MON; k++) begin
      j = (int'(last_grant_q) + k) % N_MON;
      if (!found && pending[j]) begin
        found = 1'b1;
        gnt   = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rpt_valid    <= 1'b0;
      rpt_idx      <= '0;
      last_grant_q <= IDX_W'(N_MON - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_go) begin
            rpt_idx   <= gnt;
            rpt_valid <= 1'b1;
            state_q   <= REPORT;
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            rpt_valid    <= 1'b0;
            last_grant_q <= rpt_idx;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CSR_DEC_DEADLOCK_TIMESTAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] ts_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      ts_q  <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (grant_go) begin
        ts_q <= cyc_q;
      end
    end
  end

  assign rpt_ts = ts_q;
`else
  assign rpt_ts = '0;
`endif

endmodule
